conjunto_reg32x32: RTL and testbench
====================================

CONJUNTO_REG32X32 -- requirements
Module: conjunto_reg32x32

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 32 registers x 32 bits with 5-bit addresses.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 write_enable  input  1  write strobe, sampled on rising clk edge.
REQ-005 write_addr  input  5  destination register index.
REQ-006 write_data  input  32  data to write.
REQ-007 read_addr1  input  5  read port 1 register index.
REQ-008 read_addr2  input  5  read port 2 register index.
REQ-009 read_data1  output  32  contents of register read_addr1.
REQ-010 read_data2  output  32  contents of register read_addr2.

Function
REQ-011 The block SHALL hold 32 registers x0..x31 of 32 bits each; this is the RV32I integer register file.
REQ-012 Write: on rising clk with rst_n high and write_enable=1, register[write_addr] SHALL take write_data; the new value is visible after that edge.
REQ-013 write_enable=0 SHALL leave all registers unchanged, regardless of write_addr or write_data.
REQ-014 Register x0 SHALL read as 32'h0 at all times; writes with write_addr=0 SHALL be discarded with no side effect.
REQ-015 Reads SHALL be combinational, with zero-cycle latency: read_dataN follows read_addrN and register contents without waiting for a clock.
REQ-016 The two read ports SHALL be independent; both may address the same register, and may address the write target, in the same cycle.
REQ-017 Read-during-write, with the macro absent: a read of write_addr in the write cycle SHALL return the old value until the clock edge, then the new value.
REQ-018 Outputs SHALL never be X once rst_n has been asserted at least once.

Reset
REQ-019 rst_n=0 SHALL immediately clear all 32 registers to 32'h0, independent of clk.
REQ-020 While rst_n=0, read_data1 and read_data2 SHALL be 32'h0 and writes SHALL be ignored.
REQ-021 If a write edge coincides with reset deassertion, that write SHALL be ignored; the first write accepted is on the first rising edge with rst_n already high.

Configuration
REQ-022 Macro REGFILE_BYPASS_EN, when defined, SHALL enable write-to-read forwarding.
REQ-023 With forwarding enabled, when write_enable=1, write_addr!=0 and read_addrN==write_addr, read_dataN SHALL equal write_data combinationally in that same cycle.
REQ-024 Without REGFILE_BYPASS_EN, the block SHALL implement no forwarding and SHALL follow REQ-017.
REQ-025 In both configurations, reads of x0 SHALL return 0.

Verification
REQ-026 Reset: rst_n=0 after arbitrary writes -> every read_addr returns 32'h0 immediately, with no clock edge needed.
REQ-027 x0: write_enable=1, write_addr=0, write_data=32'h5041544F, one clock -> read_addr1=0 returns 32'h0.
REQ-028 Basic write/read: write 32'h5041544F to x1, then to x2, on consecutive edges; then write_enable=0, write_data=0, read_addr1=1, read_addr2=2 -> both ports return 32'h5041544F, and the registers are unchanged on later edges.
REQ-029 Write disable: write_enable=0, write_addr=3, write_data=32'hDEADBEEF, one edge -> read of x3 returns its prior value (0 after reset).
REQ-030 Read-during-write: x5=32'h11111111, then write 32'h22222222 to x5 while reading x5 on both ports.
 - Without REGFILE_BYPASS_EN: 32'h11111111 before the edge, 32'h22222222 after it.
 - With REGFILE_BYPASS_EN: 32'h22222222 before the edge.
REQ-031 Full sweep: write value 32'hA5A50000+i to xi for i=1..31, then read all pairs (i, 31-i) -> the matching values, with x0 = 0.

Source files
------------

// File: rtl/conjunto_reg32x32.sv
// conjunto_reg32x32: RV32I integer register file, 32 x 32-bit, two combinational
// read ports and one synchronous write port.
//   clk          in   rising-edge clock for all state updates
//   rst_n        in   asynchronous active-low reset, clears every register
//   write_enable in   write strobe sampled on the rising edge
//   write_addr   in   [4:0]  destination register index
//   write_data   in   [31:0] value to write
//   read_addr1/2 in   [4:0]  read port indices
//   read_data1/2 out  [31:0] register contents (x0 always reads 0)
// Optional macro REGFILE_BYPASS_EN: forward write_data to a read port that
// addresses the register being written in the same cycle.
module conjunto_reg32x32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write_enable,
  input  logic [4:0]  write_addr,
  input  logic [31:0] write_data,
  input  logic [4:0]  read_addr1,
  input  logic [4:0]  read_addr2,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2
);
  logic [31:0][31:0] regs_q, regs_d;
  logic              wr_ok, fwd1, fwd2;
  // x0 is never written, so regs_q[0] stays at its reset value of zero.
  assign wr_ok = write_enable && (write_addr != 5'd0);
  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[write_addr] = write_data;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
`ifdef REGFILE_BYPASS_EN
  // Gated by rst_n so the outputs stay zero while reset is held.
  assign fwd1 = rst_n && wr_ok && (read_addr1 == write_addr);
  assign fwd2 = rst_n && wr_ok && (read_addr2 == write_addr);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif
  always_comb begin
    read_data1 = fwd1 ? write_data : regs_q[read_addr1];
    read_data2 = fwd2 ? write_data : regs_q[read_addr2];
  end
endmodule

// File: tb/tb_conjunto_reg32x32.sv
// tb_conjunto_reg32x32: directed self-checking bench for conjunto_reg32x32.
module tb_conjunto_reg32x32;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        write_enable = 1'b0;
  logic [4:0]  write_addr = '0;
  logic [31:0] write_data = '0;
  logic [4:0]  read_addr1 = '0;
  logic [4:0]  read_addr2 = '0;
  logic [31:0] read_data1, read_data2;
  int checks = 0;
  int errors = 0;
  conjunto_reg32x32 dut (
    .clk(clk), .rst_n(rst_n), .write_enable(write_enable),
    .write_addr(write_addr), .write_data(write_data),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_data1(read_data1), .read_data2(read_data2)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    write_enable = 1'b1;
    write_addr = a;
    write_data = d;
    tick();
    write_enable = 1'b0;
    write_data = '0;
  endtask
  task automatic rd(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                    input logic [31:0] e1, input logic [31:0] e2);
    read_addr1 = a1;
    read_addr2 = a2;
    #1;
    chk({tag, "_p1"}, read_data1, e1);
    chk({tag, "_p2"}, read_data2, e2);
  endtask
  initial begin
    #1 rst_n = 1'b0;
    #1 rd("reset_state", 5'd0, 5'd17, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    // x0 writes are discarded
    wr(5'd0, 32'h5041544F);
    rd("x0_write", 5'd0, 5'd0, 32'h0, 32'h0);
    // basic write/read
    wr(5'd1, 32'h5041544F);
    wr(5'd2, 32'h5041544F);
    rd("basic", 5'd1, 5'd2, 32'h5041544F, 32'h5041544F);
    tick();
    tick();
    rd("basic_hold", 5'd1, 5'd2, 32'h5041544F, 32'h5041544F);
    // write disabled
    @(negedge clk);
    write_enable = 1'b0;
    write_addr = 5'd3;
    write_data = 32'hDEADBEEF;
    tick();
    write_data = '0;
    rd("we_off", 5'd3, 5'd3, 32'h0, 32'h0);
    // read-during-write
    wr(5'd5, 32'h11111111);
    @(negedge clk);
    write_enable = 1'b1;
    write_addr = 5'd5;
    write_data = 32'h22222222;
`ifdef REGFILE_BYPASS_EN
    rd("rdw_before", 5'd5, 5'd5, 32'h22222222, 32'h22222222);
`else
    rd("rdw_before", 5'd5, 5'd5, 32'h11111111, 32'h11111111);
`endif
    tick();
    write_enable = 1'b0;
    rd("rdw_after", 5'd5, 5'd5, 32'h22222222, 32'h22222222);
    // full sweep
    for (int i = 1; i < 32; i++) wr(5'(i), 32'hA5A50000 + i);
    for (int i = 0; i < 32; i++)
      rd("sweep", 5'(i), 5'(31 - i),
         (i == 0) ? 32'h0 : 32'hA5A50000 + i,
         (i == 31) ? 32'h0 : 32'hA5A50000 + 31 - i);
    // asynchronous reset mid-cycle, no clock edge needed
    @(negedge clk);
    #2 rst_n = 1'b0;
    rd("async_rst", 5'd31, 5'd1, 32'h0, 32'h0);
    rd("async_rst2", 5'd5, 5'd16, 32'h0, 32'h0);
    // writes ignored while in reset
    write_enable = 1'b1;
    write_addr = 5'd7;
    write_data = 32'h77777777;
    tick();
    rd("rst_write", 5'd7, 5'd7, 32'h0, 32'h0);
    // first edge after release accepts the write
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    write_enable = 1'b0;
    rd("post_rst", 5'd7, 5'd6, 32'h77777777, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
